// File: rtl/led_sweep_gen.sv
// LED sweep generator: a one-hot pattern walks right at a speed set by LEVEL.
// A debounced button press freezes it; a HIT while frozen raises LEVEL, a miss clears it.
module led_sweep_gen #(
  parameter int DIV_BASE    = 16,
  parameter int DIV_DEC     = 2,
  parameter int DIV_MIN     = 2,
  parameter int DB_CYCLES   = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BTN_RAW,
  input  logic       HIT,
  output logic [7:0] LEDS,
  output logic       BTN,
  output logic       STEP,
  output logic [2:0] LEVEL
);

  // state | meaning
  // IDLE  | pattern parked at 8'h80, waiting for the first press
  // SWEEP | pattern rotates right once per step period
  // HOLD  | pattern frozen after a press, HIT collected for the round
  typedef enum logic [1:0] {IDLE, SWEEP, HOLD} state_t;

  localparam int PMAX = (DIV_BASE > DIV_MIN) ? DIV_BASE : DIV_MIN;
  localparam int PW   = (PMAX > 2) ? $clog2(PMAX) : 1;
  localparam int DW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int HW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic          sync_1, sync_2;
  logic          btn_lvl;
  logic [DW-1:0] db_cnt;

  state_t        state, state_n;
  logic [7:0]    leds_n;
  logic [PW-1:0] presc, presc_n, last_cnt;
  logic [2:0]    level_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic          hit_seen, hit_n;
  logic          step_n;
  logic          round_hit;
  int            period;

  // Two-flop synchronizer followed by a consecutive-sample debouncer.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      btn_lvl <= 1'b0;
      db_cnt  <= '0;
      BTN     <= 1'b0;
    end else begin
      sync_1 <= BTN_RAW;
      sync_2 <= sync_1;
      BTN    <= 1'b0;
      if (sync_2 != btn_lvl) begin
        if (db_cnt == DW'(DB_CYCLES - 1)) begin
          btn_lvl <= sync_2;
          db_cnt  <= '0;
          BTN     <= sync_2;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  always_comb begin
    period = DIV_BASE - int'(LEVEL) * DIV_DEC;
    if (period < DIV_MIN) period = DIV_MIN;
    last_cnt = PW'(period - 1);
  end

  assign round_hit = hit_seen | HIT;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      LEDS     <= 8'h80;
      presc    <= '0;
      LEVEL    <= 3'd0;
      hold_cnt <= '0;
      hit_seen <= 1'b0;
      STEP     <= 1'b0;
    end else begin
      state    <= state_n;
      LEDS     <= leds_n;
      presc    <= presc_n;
      LEVEL    <= level_n;
      hold_cnt <= hold_n;
      hit_seen <= hit_n;
      STEP     <= step_n;
    end
  end

  always_comb begin
    state_n = state;
    leds_n  = LEDS;
    presc_n = presc;
    level_n = LEVEL;
    hold_n  = hold_cnt;
    hit_n   = hit_seen;
    step_n  = 1'b0;
    case (state)
      IDLE: begin
        leds_n  = 8'h80;
        presc_n = '0;
        if (BTN) state_n = SWEEP;
      end
      SWEEP: begin
        // A press on the terminal count wins over the step.
        if (BTN) begin
          state_n = HOLD;
          hold_n  = HW'(HOLD_CYCLES - 1);
          hit_n   = 1'b0;
        end else if (presc == last_cnt) begin
          leds_n  = {LEDS[0], LEDS[7:1]};
          presc_n = '0;
          step_n  = 1'b1;
        end else begin
          presc_n = presc + 1'b1;
        end
      end
      HOLD: begin
        hit_n = round_hit;
        if (hold_cnt == '0) begin
          state_n = SWEEP;
          leds_n  = 8'h80;
          presc_n = '0;
          if (round_hit) level_n = (LEVEL == 3'd7) ? 3'd7 : LEVEL + 3'd1;
          else           level_n = 3'd0;
        end else begin
          hold_n = hold_cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        leds_n  = 8'h80;
        presc_n = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_led_sweep_gen.sv
// Bench for led_sweep_gen: reset/debounce vector table, directed round sequences,
// and random button/hit/reset traffic checked every cycle against a behavioural model.
module tb_led_sweep_gen;

  localparam int DIV_BASE = 16, DIV_DEC = 2, DIV_MIN = 2, DB_CYCLES = 4, HOLD_CYCLES = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, btn_raw = 1'b0, hit = 1'b0;
  logic [7:0] leds;
  logic       btn, step;
  logic [2:0] level;

  int checks = 0;
  int passes = 0;
  int cyc_n  = 0;

  led_sweep_gen #(
    .DIV_BASE(DIV_BASE), .DIV_DEC(DIV_DEC), .DIV_MIN(DIV_MIN),
    .DB_CYCLES(DB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .BTN_RAW(btn_raw), .HIT(hit),
    .LEDS(leds), .BTN(btn), .STEP(step), .LEVEL(level)
  );

  always #5 clk = ~clk;

  // Behavioural model: LED position index, cycles since last step, hold countdown.
  bit raw_d1, raw_d2, m_acc, m_btn, m_step, m_hit;
  int m_run, m_mode, m_pos, m_elapsed, m_hold_left, m_level;

  function automatic int period_of(int lv);
    int p;
    p = DIV_BASE - lv * DIV_DEC;
    return (p < DIV_MIN) ? DIV_MIN : p;
  endfunction

  task automatic model_edge(bit r, bit raw, bit h);
    bit synced, new_btn, new_step;
    if (!r) begin
      raw_d1 = 0; raw_d2 = 0; m_acc = 0; m_btn = 0; m_step = 0; m_hit = 0;
      m_run = 0; m_mode = 0; m_pos = 0; m_elapsed = 0; m_hold_left = 0; m_level = 0;
      return;
    end
    synced   = raw_d2;
    new_btn  = 0;
    new_step = 0;
    if (m_mode == 0) begin
      if (m_btn) begin m_mode = 1; m_elapsed = 0; end
    end else if (m_mode == 1) begin
      if (m_btn) begin
        m_mode = 2; m_hold_left = HOLD_CYCLES; m_hit = 0;
      end else if (m_elapsed + 1 == period_of(m_level)) begin
        m_pos = (m_pos + 1) % 8; m_elapsed = 0; new_step = 1;
      end else begin
        m_elapsed++;
      end
    end else begin
      if (h) m_hit = 1;
      m_hold_left--;
      if (m_hold_left == 0) begin
        m_mode = 1; m_pos = 0; m_elapsed = 0;
        m_level = m_hit ? ((m_level < 7) ? m_level + 1 : 7) : 0;
      end
    end
    if (synced != m_acc) begin
      m_run++;
      if (m_run == DB_CYCLES) begin
        m_acc = synced; m_run = 0; new_btn = synced;
      end
    end else begin
      m_run = 0;
    end
    raw_d2 = raw_d1;
    raw_d1 = raw;
    m_btn  = new_btn;
    m_step = new_step;
  endtask

  task automatic check(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc_n, act, exp);
  endtask

  task automatic cyc(bit r, bit raw, bit h);
    logic [7:0] e_leds;
    @(negedge clk);
    rst_n = r; btn_raw = raw; hit = h;
    @(posedge clk);
    #1;
    model_edge(r, raw, h);
    cyc_n++;
    e_leds = 8'h80 >> m_pos;
    check("model", {leds, btn, step, level}, {e_leds, m_btn, m_step, 3'(m_level)});
  endtask

  task automatic wait_step(output int dt);
    dt = 0;
    do begin
      cyc(1, 0, 0);
      dt++;
    end while (!step && dt < 100);
    check("step_timeout", int'(step), 1);
  endtask

  task automatic press();
    int n;
    n = 0;
    do begin
      cyc(1, 1, 0);
      n++;
    end while (!btn && n < 20);
    check("press_btn", int'(btn), 1);
  endtask

  task automatic hit_round(bit h);
    press();
    cyc(1, 0, 0);
    cyc(1, 0, h);
    repeat (7) cyc(1, 0, 0);
  endtask

  typedef struct {
    bit         rst;
    bit         raw;
    bit         h;
    logic [7:0] e_leds;
    bit         e_btn;
    bit         e_step;
    logic [2:0] e_level;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int dt, n;
    bit any_step;
    logic [7:0] walk[8];

    for (int i = 0; i < 18; i++) begin
      tbl[i].rst     = (i >= 2);
      tbl[i].raw     = (i >= 2 && i <= 4) || (i >= 11);
      tbl[i].h       = (i == 7 || i == 8);
      tbl[i].e_leds  = 8'h80;
      tbl[i].e_btn   = (i == 16);
      tbl[i].e_step  = 0;
      tbl[i].e_level = 3'd0;
    end

    // Reset, 3-cycle glitch (no pulse), held press (pulse 6 edges after first high sample)
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].rst, tbl[i].raw, tbl[i].h);
      check($sformatf("tbl[%0d]", i), {leds, btn, step, level},
            {tbl[i].e_leds, tbl[i].e_btn, tbl[i].e_step, tbl[i].e_level});
    end

    // Full walk at LEVEL 0: period 16
    walk = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
    for (int k = 0; k < 8; k++) begin
      wait_step(dt);
      check("walk_period", dt, 16);
      check("walk_leds", int'(leds), int'(walk[k]));
    end

    // Press while LEDS=10, HIT during HOLD
    n = 0;
    while (leds != 8'h10 && n < 200) begin cyc(1, 0, 0); n++; end
    check("reach_10", int'(leds), 8'h10);
    press();
    check("press_at_10", int'(leds), 8'h10);
    cyc(1, 0, 0);
    check("hold_leds_1", int'(leds), 8'h10);
    cyc(1, 0, 1);
    for (int i = 3; i <= 8; i++) begin
      cyc(1, 0, 0);
      check("hold_frozen", int'(leds), 8'h10);
    end
    cyc(1, 0, 0);
    check("exit_leds", int'(leds), 8'h80);
    check("exit_level", int'(level), 1);
    wait_step(dt);
    check("lvl1_period", dt, 14);
    check("lvl1_leds", int'(leds), 8'h40);

    // Up to LEVEL 3, HIT in SWEEP ignored, then a miss clears LEVEL
    hit_round(1);
    hit_round(1);
    check("level3", int'(level), 3);
    repeat (5) cyc(1, 0, 1);
    check("sweep_hit_ignored", int'(level), 3);
    hit_round(0);
    check("miss_clears", int'(level), 0);

    // Seven hits saturate at 7 with period 2
    for (int k = 0; k < 7; k++) hit_round(1);
    check("level7", int'(level), 7);
    wait_step(dt);
    check("lvl7_period_a", dt, 2);
    wait_step(dt);
    check("lvl7_period_b", dt, 2);
    hit_round(1);
    check("level7_sat", int'(level), 7);

    // Reset mid-HOLD discards the pending hit
    press();
    cyc(1, 0, 0);
    cyc(1, 0, 1);
    cyc(0, 0, 0);
    check("rst_level", int'(level), 0);
    check("rst_leds", int'(leds), 8'h80);
    any_step = 0;
    repeat (20) begin
      cyc(1, 0, 0);
      if (step) any_step = 1;
    end
    check("idle_no_step", int'(any_step), 0);
    check("idle_leds", int'(leds), 8'h80);

    // Random traffic against the model
    begin
      bit rl, hh, rr;
      rl = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 11) == 0) rl = ~rl;
        rr = ($urandom_range(0, 499) != 0);
        hh = ($urandom_range(0, 5) == 0);
        cyc(rr, ($urandom_range(0, 19) == 0) ? ~rl : rl, hh);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
